// File: rtl/rf_sb_pkg.sv
// Shared constants, error-cause enum and counter helper for the rf_scoreboard register file.
package rf_sb_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int NRD_DEF    = 2;
   localparam int CNT_W_DEF  = 2;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_OVERFLOW,
      ERR_UNDERFLOW
   } err_cause_e;

   function automatic int cnt_max(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/rf_sb_counter.sv
// Saturating pending-write counter for one register; flags issue-at-max and retire-at-zero.
module rf_sb_counter
   import rf_sb_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             nz,
   output logic             ovf,
   output logic             unf
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

   logic at_max;
   logic zero;

   assign at_max = (count == MAX);
   assign zero   = (count == '0);
   assign nz     = ~zero;

   // Flush wins over everything, so neither error can be raised in a clearing cycle.
   assign ovf = inc & ~dec & ~clr & at_max;
   assign unf = dec & ~inc & ~clr & zero;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !dec && !at_max) begin
         count <= count + 1'b1;
      end else if (dec && !inc && !zero) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/rf_scoreboard.sv
// Decode-stage register file with per-register pending-write scoreboard and stall generation.
// Optional same-cycle write bypass: define RF_SCOREBOARD_BYPASS_EN.
module rf_scoreboard
   import rf_sb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = NRD_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*ADDR_W-1:0] rd_sel,
   input  logic [NRD-1:0]        rd_use,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic                  stall,
   input  logic                  iss_en,
   input  logic [ADDR_W-1:0]     iss_dst,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_sel,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  wr_pend,
   input  logic                  flush,
   output logic [2**ADDR_W-1:0]  pend_vec,
   output logic                  err
);

   localparam int NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [CNT_W-1:0]  cnt  [NREGS];
   logic [NREGS-1:0]  inc, dec, nz, ovf, unf;
   logic [NRD-1:0]    blk;
   logic              iss_fire;
   logic              ret;
   err_cause_e        cause;

   assign iss_fire = iss_en & ~stall;
   assign ret      = wr_en & wr_pend;

   // NOTE: the storage array is reset because software may read any register before writing it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (wr_en) begin
         regs[wr_sel] <= wr_data;
      end
   end

   for (genvar r = 0; r < NREGS; r++) begin : g_cnt
      assign inc[r] = iss_fire & (iss_dst == ADDR_W'(r));
      assign dec[r] = ret & (wr_sel == ADDR_W'(r));

      rf_sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (inc[r]),
         .dec   (dec[r]),
         .clr   (flush),
         .count (cnt[r]),
         .nz    (nz[r]),
         .ovf   (ovf[r]),
         .unf   (unf[r])
      );

      a_nz_consistent: assert property (@(posedge clk) disable iff (rst)
         nz[r] == (cnt[r] != '0));
   end

   assign pend_vec = nz;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] sel;
      logic              hit;

      assign sel = rd_sel[i*ADDR_W +: ADDR_W];
`ifdef RF_SCOREBOARD_BYPASS_EN
      assign rd_data[i*DATA_W +: DATA_W] = (wr_en && (wr_sel == sel)) ? wr_data : regs[sel];
      // The last outstanding writer retiring now releases the operand via the bypass path.
      assign hit = ret & (wr_sel == sel) & (cnt[sel] == CNT_W'(1));
`else
      assign rd_data[i*DATA_W +: DATA_W] = regs[sel];
      assign hit = 1'b0;
`endif
      assign blk[i] = rd_use[i] & nz[sel] & ~hit;
   end

   assign stall = |blk;

   // NOTE: always_comb gives cause a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cause = ERR_NONE;
      if (|ovf)      cause = ERR_OVERFLOW;
      else if (|unf) cause = ERR_UNDERFLOW;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (cause != ERR_NONE) begin
         err <= 1'b1;
      end
   end

   a_err_sticky: assert property (@(posedge clk) disable iff (rst)
      (cause != ERR_NONE) |=> err);

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard; expectations follow RF_SCOREBOARD_BYPASS_EN.
module tb_rf_scoreboard;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int NR = 2;

`ifdef RF_SCOREBOARD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*AW-1:0]  rd_sel;
   logic [NR-1:0]     rd_use;
   logic [NR*DW-1:0]  rd_data;
   logic              stall;
   logic              iss_en;
   logic [AW-1:0]     iss_dst;
   logic              wr_en;
   logic [AW-1:0]     wr_sel;
   logic [DW-1:0]     wr_data;
   logic              wr_pend;
   logic              flush;
   logic [2**AW-1:0]  pend_vec;
   logic              err;

   int checks   = 0;
   int failures = 0;

   rf_scoreboard dut (
      .clk      (clk),
      .rst      (rst),
      .rd_sel   (rd_sel),
      .rd_use   (rd_use),
      .rd_data  (rd_data),
      .stall    (stall),
      .iss_en   (iss_en),
      .iss_dst  (iss_dst),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .wr_pend  (wr_pend),
      .flush    (flush),
      .pend_vec (pend_vec),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_en = 1'b0; wr_en = 1'b0; wr_pend = 1'b0; flush = 1'b0;
   endtask

   task automatic retire(input logic [AW-1:0] r, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_pend = 1'b1; wr_sel = r; wr_data = d;
   endtask

   initial begin
      rst = 1'b1; rd_sel = '0; rd_use = '0; iss_dst = '0;
      wr_sel = '0; wr_data = '0;
      idle();
      #17 rst = 1'b0;
      #1;

      // Reset state on every register, both ports
      for (int r = 0; r < 8; r++) begin
         rd_sel = {AW'(r), AW'(r)};
         #1;
         check($sformatf("rst_rd0_r%0d", r), 32'(rd_data[DW-1:0]), 32'h0);
         check($sformatf("rst_rd1_r%0d", r), 32'(rd_data[2*DW-1:DW]), 32'h0);
      end
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_pend", 32'(pend_vec), 32'h0);
      check("rst_err", 32'(err), 32'h0);

      // Plain write r3 and same-cycle read
      tick();
      wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hBEEF; rd_sel = {3'd0, 3'd3};
      #1;
      check("wr_same_cycle", 32'(rd_data[DW-1:0]), BYP ? 32'hBEEF : 32'h0);
      tick();
      idle();
      #1;
      check("wr_next_cycle", 32'(rd_data[DW-1:0]), 32'hBEEF);

      // Issue to r5, dependent read stalls, retire releases
      iss_en = 1'b1; iss_dst = 3'd5; rd_use = '0;
      tick();
      idle();
      rd_sel = {3'd0, 3'd5}; rd_use = 2'b01;
      #1;
      check("r5_stall", 32'(stall), 32'h1);
      check("r5_pend", 32'(pend_vec), 32'h20);
      retire(3'd5, 16'h1234);
      #1;
      check("r5_ret_stall", 32'(stall), BYP ? 32'h0 : 32'h1);
      if (BYP) check("r5_ret_byp", 32'(rd_data[DW-1:0]), 32'h1234);
      tick();
      idle();
      #1;
      check("r5_after_stall", 32'(stall), 32'h0);
      check("r5_after_pend", 32'(pend_vec), 32'h0);
      check("r5_after_data", 32'(rd_data[DW-1:0]), 32'h1234);

      // Two issues to r2, retire one, same-cycle issue+retire, retire last
      rd_use = '0; iss_en = 1'b1; iss_dst = 3'd2;
      tick();
      tick();
      idle();
      rd_sel = {3'd0, 3'd2}; rd_use = 2'b01;
      retire(3'd2, 16'h0002);
      #1;
      check("r2_cnt2_ret_stall", 32'(stall), 32'h1);
      tick();
      idle();
      #1;
      check("r2_cnt1_stall", 32'(stall), 32'h1);
      check("r2_cnt1_pend", 32'(pend_vec), 32'h04);
      rd_use = '0; iss_en = 1'b1; iss_dst = 3'd2;
      retire(3'd2, 16'h0022);
      tick();
      idle();
      rd_use = 2'b01;
      #1;
      check("r2_issret_pend", 32'(pend_vec), 32'h04);
      check("r2_issret_stall", 32'(stall), 32'h1);
      retire(3'd2, 16'h0222);
      #1;
      check("r2_last_ret_stall", 32'(stall), BYP ? 32'h0 : 32'h1);
      tick();
      idle();
      #1;
      check("r2_clear_pend", 32'(pend_vec), 32'h0);
      check("r2_clear_stall", 32'(stall), 32'h0);
      check("r2_no_err", 32'(err), 32'h0);

      // Overflow on r7: count saturates at 3
      rd_use = '0; iss_en = 1'b1; iss_dst = 3'd7;
      tick(); tick(); tick();
      check("r7_three_err", 32'(err), 32'h0);
      check("r7_three_pend", 32'(pend_vec), 32'h80);
      tick();
      idle();
      #1;
      check("r7_ovf_err", 32'(err), 32'h1);
      check("r7_ovf_pend", 32'(pend_vec), 32'h80);
      retire(3'd7, 16'h0007);
      tick(); tick();
      check("r7_two_ret_pend", 32'(pend_vec), 32'h80);
      tick();
      idle();
      #1;
      check("r7_three_ret_pend", 32'(pend_vec), 32'h0);

      // Underflow on r1, sticky until rst
      rst = 1'b1;
      #1;
      check("rst_clears_err", 32'(err), 32'h0);
      rst = 1'b0;
      retire(3'd1, 16'h0001);
      tick();
      idle();
      #1;
      check("r1_unf_err", 32'(err), 32'h1);
      check("r1_unf_pend", 32'(pend_vec), 32'h0);
      tick(); tick();
      check("r1_err_sticky", 32'(err), 32'h1);
      rst = 1'b1;
      #1;
      check("r1_err_rst", 32'(err), 32'h0);
      rst = 1'b0;

      // Flush overrides a simultaneous issue
      iss_en = 1'b1; iss_dst = 3'd4;
      tick();
      iss_dst = 3'd6;
      tick();
      idle();
      #1;
      check("r46_pend", 32'(pend_vec), 32'h50);
      flush = 1'b1; iss_en = 1'b1; iss_dst = 3'd0;
      tick();
      idle();
      #1;
      check("flush_pend", 32'(pend_vec), 32'h0);
      check("flush_err", 32'(err), 32'h0);

      // Asynchronous reset during a stall
      iss_en = 1'b1; iss_dst = 3'd4;
      tick();
      idle();
      rd_sel = {3'd0, 3'd4}; rd_use = 2'b01;
      #1;
      check("r4_stall", 32'(stall), 32'h1);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_stall", 32'(stall), 32'h0);
      check("rst_mid_pend", 32'(pend_vec), 32'h0);
      check("rst_mid_data", 32'(rd_data[DW-1:0]), 32'h0);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised register file for the decode stage with an integrated per-register scoreboard. Provides NRD combinational read ports and one synchronous write port. Tracks outstanding long-latency writers (loads, multi-cycle ops) per destination register, and raises a decode stall when a used source register still has a pending write. It replaces the fixed 8×16-bit two-port file and moves hazard interlock out of the pipeline control.

## Interface
- DATA_W, 16: register width in bits
- ADDR_W, 3: register select width; NREGS = 2**ADDR_W
- NRD, 2: number of read ports
- CNT_W, 2: pending-counter width; up to 2**CNT_W-1 outstanding writes per register

Reset and clock (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- rd_sel  in  NRD*ADDR_W  read selects; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_use  in  NRD  port i is a real source operand (participates in stall)
- rd_data  out  NRD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
- stall  out  1  decode must hold the current instruction
- iss_en  in  1  issuing instruction has a scoreboarded destination
- iss_dst  in  ADDR_W  its destination register
- wr_en  in  1  writeback enable
- wr_sel  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback data
- wr_pend  in  1  this writeback retires a scoreboarded issue
- flush  in  1  clear all pending counts
- pend_vec  out  NREGS  bit r = count[r] != 0
- err  out  1  sticky scoreboard error

## Operation
- Storage:
  - NREGS×DATA_W registers; all are general purpose (register 0 is not hardwired).
  - Write occurs at the clk edge when wr_en = 1.
- Read: rd_data[i] = reg[rd_sel[i]], combinational.
- Counters: count[r] is CNT_W bits. Effective issue: iss_fire = iss_en & ~stall. Effective retire: ret = wr_en & wr_pend.
- Per-register next count:
  - flush = 1: count becomes 0. Flush overrides issue and retire; data writes still occur.
  - iss_fire and ret both targeting r: count unchanged.
  - Only iss_fire to r: count + 1.
  - Only ret to r: count - 1.
- Errors:
  - Issue to a register whose count is at max: count holds, err is set.
  - Retire to a register whose count is 0 (no flush that cycle): count holds, err is set.
  - err clears only on rst.
- Stall:
  - A port is blocked when rd_use[i] & (count[rd_sel[i]] != 0) & ~hit[i].
  - hit[i] is defined only in bypass mode (see Configuration).
  - stall is the OR of all port blocks and is combinational from inputs and state.
- pend_vec is combinational from the counters.
- Usage rule: the pipeline asserts flush only when no older scoreboarded write is still in flight.

## Timing
- Reset values:
  - all registers = 0
  - all counts = 0
  - err = 0
  - therefore pend_vec = 0, stall = 0, rd_data = 0 for every select
- Write-to-read latency: 1 cycle without bypass; 0 cycles with bypass.
- Issue-to-stall: a dependent instruction in the cycle after iss_fire sees count ≥ 1 and stalls.
- Simultaneous issue and read of the same register in one cycle: stall uses the registered count, so an instruction does not stall on its own destination.
- rst asserted mid-operation: all state is cleared immediately, with no clock needed.

## Configuration
- Macro: RF_SCOREBOARD_BYPASS_EN.
- With the macro defined:
  - When wr_en & wr_sel == rd_sel[i], rd_data[i] = wr_data in the same cycle.
  - hit[i] = wr_en & wr_pend & (wr_sel == rd_sel[i]) & (count == 1).
- Without the macro:
  - rd_data always shows stored contents.
  - hit[i] = 0, so stall persists through the retiring cycle and drops the next cycle.

## Structure
- Package rf_sb_pkg holds:
  - default parameter constants (DATA_W, ADDR_W, NRD, CNT_W)
  - a CNT_MAX constant function
  - an error-cause enum (NONE, OVERFLOW, UNDERFLOW) for assertions
- Sub-module rf_sb_counter: one per register, CNT_W bits. Inputs inc, dec, clr; outputs count, nz, ovf, unf. Instantiated NREGS times.

## Test plan
- Reset, then read all 8 regs on both ports -> rd_data = 0, stall = 0, pend_vec = 0, err = 0.
- Write r3 = 0xBEEF, read r3 on the same cycle -> 0xBEEF with bypass, 0x0000 without; 0xBEEF on the next cycle in both builds.
- iss_en to r5; next cycle rd_sel0 = 5, rd_use0 = 1 -> stall = 1. Then wr_en, wr_pend, wr_sel = 5, data 0x1234 -> stall = 0 that cycle (bypass, rd_data0 = 0x1234) or the next cycle (no bypass); pend_vec[5] returns to 0.
- Two issues to r2, then one retire -> count = 1, stall persists. Second retire clears it. Same-cycle issue and retire on r2 -> count unchanged.
- Three issues to r7 (CNT_W = 2) then a fourth -> count = 3, err = 1. Separately, retire to r1 with count 0 -> err = 1, which persists until rst.
- Pend r4 and r6, then flush together with iss_en to r0 -> all counts 0, pend_vec = 0, no err. Assert rst mid-stall -> stall drops immediately.
